// File: rtl/rat_ckpt.sv
// Register alias table for the rename stage. It maps architectural registers to
// in-flight ROB entries and keeps CKPT_NUM branch snapshots for one-cycle recovery.
module rat_ckpt #(
  parameter  int MACHINE_WIDTH = 2,
  parameter  int RETIRE_PORTS  = 2,
  parameter  int AREG_NUM      = 32,
  parameter  int ROB_W         = 4,
  parameter  int CKPT_NUM      = 4,
  localparam int AREG_W        = $clog2(AREG_NUM),
  localparam int CKPT_W        = $clog2(CKPT_NUM)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MACHINE_WIDTH-1:0]          ren_valid,
  input  logic [MACHINE_WIDTH*AREG_W-1:0]   ren_src1,
  input  logic [MACHINE_WIDTH*AREG_W-1:0]   ren_src2,
  input  logic [MACHINE_WIDTH*AREG_W-1:0]   ren_dst,
  input  logic [MACHINE_WIDTH*ROB_W-1:0]    ren_rob,
  output logic [MACHINE_WIDTH-1:0]          src1_valid,
  output logic [MACHINE_WIDTH*ROB_W-1:0]    src1_id,
  output logic [MACHINE_WIDTH-1:0]          src2_valid,
  output logic [MACHINE_WIDTH*ROB_W-1:0]    src2_id,
  output logic [MACHINE_WIDTH-1:0]          dst_old_valid,
  output logic [MACHINE_WIDTH*ROB_W-1:0]    dst_old_id,
  input  logic [RETIRE_PORTS-1:0]           ret_valid,
  input  logic [RETIRE_PORTS*AREG_W-1:0]    ret_dst,
  input  logic [RETIRE_PORTS*ROB_W-1:0]     ret_rob,
  input  logic                              ckpt_req,
  output logic                              ckpt_ready,
  output logic [CKPT_W-1:0]                 ckpt_tag,
  input  logic                              ckpt_free,
  input  logic                              recover,
  input  logic [CKPT_W-1:0]                 recover_tag,
  input  logic                              flush
);

  localparam logic [CKPT_W:0] CKPT_FULL = (CKPT_W+1)'(CKPT_NUM);

  logic             r_tv  [AREG_NUM];
  logic [ROB_W-1:0] r_tid [AREG_NUM];
  logic             r_cv  [CKPT_NUM][AREG_NUM];
  logic [ROB_W-1:0] r_cid [CKPT_NUM][AREG_NUM];
  logic [CKPT_W-1:0] r_head;
  logic [CKPT_W-1:0] r_tail;
  logic [CKPT_W:0]   r_count;

  logic             w_rv  [AREG_NUM];
  logic             w_cv  [CKPT_NUM][AREG_NUM];
  logic             w_nv  [AREG_NUM];
  logic [ROB_W-1:0] w_nid [AREG_NUM];
  logic             w_alloc;
  logic             w_free;
  logic [CKPT_W-1:0] w_rdiff;
  logic [CKPT_W:0]   w_rcnt;

  // Retire compare-and-clear, applied to the live table and every snapshot.
  always_comb begin
    for (int a = 0; a < AREG_NUM; a++) begin
      w_rv[a] = r_tv[a];
      for (int k = 0; k < CKPT_NUM; k++) w_cv[k][a] = r_cv[k][a];
      for (int p = 0; p < RETIRE_PORTS; p++) begin
        if (ret_valid[p] && ret_dst[p*AREG_W +: AREG_W] == AREG_W'(a)) begin
          if (r_tid[a] == ret_rob[p*ROB_W +: ROB_W]) w_rv[a] = 1'b0;
          for (int k = 0; k < CKPT_NUM; k++)
            if (r_cid[k][a] == ret_rob[p*ROB_W +: ROB_W]) w_cv[k][a] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    logic [AREG_W-1:0] sel;
    logic              v;
    logic [ROB_W-1:0]  id;
    src1_valid    = '0;
    src1_id       = '0;
    src2_valid    = '0;
    src2_id       = '0;
    dst_old_valid = '0;
    dst_old_id    = '0;
    sel           = '0;
    v             = 1'b0;
    id            = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      for (int k = 0; k < 3; k++) begin
        case (k)
          0:       sel = ren_src1[i*AREG_W +: AREG_W];
          1:       sel = ren_src2[i*AREG_W +: AREG_W];
          default: sel = ren_dst[i*AREG_W +: AREG_W];
        endcase
        v  = w_rv[sel];
        id = r_tid[sel];
        // Older slots in the same group forward; ascending order leaves the youngest.
        for (int j = 0; j < i; j++) begin
          if (ren_valid[j] && ren_dst[j*AREG_W +: AREG_W] == sel) begin
            v  = 1'b1;
            id = ren_rob[j*ROB_W +: ROB_W];
          end
        end
        if (sel == '0) begin
          v  = 1'b0;
          id = '0;
        end
        case (k)
          0: begin
            src1_valid[i]              = v;
            src1_id[i*ROB_W +: ROB_W]  = id;
          end
          1: begin
            src2_valid[i]              = v;
            src2_id[i*ROB_W +: ROB_W]  = id;
          end
          default: begin
            dst_old_valid[i]             = v;
            dst_old_id[i*ROB_W +: ROB_W] = id;
          end
        endcase
      end
    end
  end

  always_comb begin
    logic [AREG_W-1:0] d;
    d = '0;
    for (int a = 0; a < AREG_NUM; a++) begin
      w_nv[a]  = w_rv[a];
      w_nid[a] = r_tid[a];
    end
    if (flush) begin
      for (int a = 0; a < AREG_NUM; a++) begin
        w_nv[a]  = 1'b0;
        w_nid[a] = '0;
      end
    end else if (recover) begin
      for (int a = 0; a < AREG_NUM; a++) begin
        w_nv[a]  = w_cv[recover_tag][a];
        w_nid[a] = r_cid[recover_tag][a];
      end
    end else begin
      for (int j = 0; j < MACHINE_WIDTH; j++) begin
        d = ren_dst[j*AREG_W +: AREG_W];
        if (ren_valid[j] && d != '0) begin
          w_nv[d]  = 1'b1;
          w_nid[d] = ren_rob[j*ROB_W +: ROB_W];
        end
      end
    end
  end

  assign w_alloc    = ckpt_req && (r_count < CKPT_FULL) && !recover && !flush;
  assign w_free     = ckpt_free && (r_count != '0);
  // Distance from head to the recovered tag; zero means the ring is fully live.
  assign w_rdiff    = recover_tag - r_head + CKPT_W'(1);
  assign w_rcnt     = (w_rdiff == '0) ? CKPT_FULL : {1'b0, w_rdiff};
  assign ckpt_ready = (r_count < CKPT_FULL);
  assign ckpt_tag   = r_tail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < AREG_NUM; a++) begin
        r_tv[a]  <= 1'b0;
        r_tid[a] <= '0;
      end
      for (int k = 0; k < CKPT_NUM; k++) begin
        for (int a = 0; a < AREG_NUM; a++) begin
          r_cv[k][a]  <= 1'b0;
          r_cid[k][a] <= '0;
        end
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int a = 0; a < AREG_NUM; a++) begin
        r_tv[a]  <= w_nv[a];
        r_tid[a] <= w_nid[a];
      end
      for (int k = 0; k < CKPT_NUM; k++) begin
        for (int a = 0; a < AREG_NUM; a++) begin
          if (flush) begin
            r_cv[k][a]  <= 1'b0;
            r_cid[k][a] <= '0;
          end else if (w_alloc && r_tail == CKPT_W'(k)) begin
            r_cv[k][a]  <= w_nv[a];
            r_cid[k][a] <= w_nid[a];
          end else begin
            r_cv[k][a]  <= w_cv[k][a];
          end
        end
      end
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else if (recover) begin
        r_head  <= r_head + CKPT_W'(w_free);
        r_tail  <= recover_tag + CKPT_W'(1);
        r_count <= w_rcnt - (CKPT_W+1)'(w_free);
      end else begin
        r_head  <= r_head + CKPT_W'(w_free);
        r_tail  <= r_tail + CKPT_W'(w_alloc);
        r_count <= r_count + (CKPT_W+1)'(w_alloc) - (CKPT_W+1)'(w_free);
      end
    end
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// Scoreboarded bench for rat_ckpt: a queue-of-snapshots reference model predicts the
// combinational read outputs each cycle; a negedge monitor compares them.
module tb_rat_ckpt;

  logic       clk;
  logic       reset;
  logic [1:0] ren_valid;
  logic [9:0] ren_src1, ren_src2, ren_dst;
  logic [7:0] ren_rob;
  logic [1:0] src1_valid, src2_valid, dst_old_valid;
  logic [7:0] src1_id, src2_id, dst_old_id;
  logic [1:0] ret_valid;
  logic [9:0] ret_dst;
  logic [7:0] ret_rob;
  logic       ckpt_req, ckpt_ready, ckpt_free, recover, flush;
  logic [1:0] ckpt_tag, recover_tag;

  rat_ckpt dut (
    .clk(clk), .reset(reset),
    .ren_valid(ren_valid), .ren_src1(ren_src1), .ren_src2(ren_src2),
    .ren_dst(ren_dst), .ren_rob(ren_rob),
    .src1_valid(src1_valid), .src1_id(src1_id),
    .src2_valid(src2_valid), .src2_id(src2_id),
    .dst_old_valid(dst_old_valid), .dst_old_id(dst_old_id),
    .ret_valid(ret_valid), .ret_dst(ret_dst), .ret_rob(ret_rob),
    .ckpt_req(ckpt_req), .ckpt_ready(ckpt_ready), .ckpt_tag(ckpt_tag),
    .ckpt_free(ckpt_free), .recover(recover), .recover_tag(recover_tag),
    .flush(flush)
  );

  typedef struct packed {
    logic [1:0] rv;
    logic [9:0] s1, s2, d;
    logic [7:0] rob;
    logic [1:0] retv;
    logic [9:0] retd;
    logic [7:0] retr;
    logic       creq, cfree, rec;
    logic [1:0] rtag;
    logic       fl;
  } stim_t;

  typedef struct packed {
    logic [31:0]      v;
    logic [31:0][3:0] id;
  } tbl_t;

  typedef struct packed {
    logic [1:0] s1v, s2v, dv;
    logic [7:0] s1id, s2id, did, s1m, s2m, dm;
    logic       rdy;
    logic [1:0] tag;
  } exp_t;

  tbl_t m_tbl;
  tbl_t q_tbl[$];
  int   q_tag[$];
  int   m_next;
  exp_t q_exp[$];

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout, queue depth %0d required 0", q_exp.size());
    $fatal(1, "watchdog");
  end

  function automatic tbl_t retire_clear(tbl_t t, stim_t s);
    for (int p = 0; p < 2; p++) begin
      if (s.retv[p]) begin
        logic [4:0] a;
        a = s.retd[p*5 +: 5];
        if (t.v[a] && t.id[a] == s.retr[p*4 +: 4]) t.v[a] = 1'b0;
      end
    end
    return t;
  endfunction

  function automatic void lookup(input tbl_t rt, input stim_t s, input int i,
                                 input logic [4:0] a, output logic v, output logic [3:0] id);
    v  = rt.v[a];
    id = rt.id[a];
    for (int j = i - 1; j >= 0; j--) begin
      if (s.rv[j] && s.d[j*5 +: 5] == a) begin
        v  = 1'b1;
        id = s.rob[j*4 +: 4];
        break;
      end
    end
    if (a == 5'd0) begin
      v  = 1'b0;
      id = 4'd0;
    end
  endfunction

  function automatic void model_reset();
    m_tbl = '0;
    q_tbl.delete();
    q_tag.delete();
    m_next = 0;
  endfunction

  function automatic exp_t model_step(stim_t s);
    exp_t       e;
    tbl_t       rt;
    logic       v;
    logic [3:0] id, m;
    logic [4:0] a;
    int         n0, idx;
    e  = '0;
    rt = retire_clear(m_tbl, s);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) begin
        a = (k == 0) ? s.s1[i*5 +: 5] : (k == 1) ? s.s2[i*5 +: 5] : s.d[i*5 +: 5];
        lookup(rt, s, i, a, v, id);
        m = (v || a == 5'd0) ? 4'hF : 4'h0;
        if (k == 0) begin e.s1v[i] = v; e.s1id[i*4 +: 4] = id & m; e.s1m[i*4 +: 4] = m; end
        else if (k == 1) begin e.s2v[i] = v; e.s2id[i*4 +: 4] = id & m; e.s2m[i*4 +: 4] = m; end
        else begin e.dv[i] = v; e.did[i*4 +: 4] = id & m; e.dm[i*4 +: 4] = m; end
      end
    end
    e.rdy = (q_tag.size() < 4);
    e.tag = 2'(m_next);

    n0 = q_tag.size();
    if (s.fl) begin
      model_reset();
    end else begin
      foreach (q_tbl[k]) q_tbl[k] = retire_clear(q_tbl[k], s);
      if (s.rec) begin
        idx = -1;
        foreach (q_tag[k]) if (q_tag[k] == int'(s.rtag)) idx = k;
        if (idx < 0) begin
          n_bad++;
          $display("FAIL model: recover tag %0d not live, required a live tag", s.rtag);
        end else begin
          m_tbl = q_tbl[idx];
          while (q_tag.size() > idx + 1) begin
            void'(q_tag.pop_back());
            void'(q_tbl.pop_back());
          end
          m_next = (int'(s.rtag) + 1) % 4;
          if (s.cfree && n0 > 0) begin
            void'(q_tag.pop_front());
            void'(q_tbl.pop_front());
          end
        end
      end else begin
        m_tbl = rt;
        for (int j = 0; j < 2; j++) begin
          if (s.rv[j] && s.d[j*5 +: 5] != 5'd0) begin
            m_tbl.v[s.d[j*5 +: 5]]  = 1'b1;
            m_tbl.id[s.d[j*5 +: 5]] = s.rob[j*4 +: 4];
          end
        end
        if (s.creq && n0 < 4) begin
          q_tbl.push_back(m_tbl);
          q_tag.push_back(m_next);
          m_next = (m_next + 1) % 4;
        end
        if (s.cfree && n0 > 0) begin
          void'(q_tag.pop_front());
          void'(q_tbl.pop_front());
        end
      end
    end
    return e;
  endfunction

  task automatic apply(input stim_t s);
    ren_valid   = s.rv;
    ren_src1    = s.s1;
    ren_src2    = s.s2;
    ren_dst     = s.d;
    ren_rob     = s.rob;
    ret_valid   = s.retv;
    ret_dst     = s.retd;
    ret_rob     = s.retr;
    ckpt_req    = s.creq;
    ckpt_free   = s.cfree;
    recover     = s.rec;
    recover_tag = s.rtag;
    flush       = s.fl;
    q_exp.push_back(model_step(s));
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    int    r;
    s    = '0;
    s.rv = 2'($urandom_range(0, 3));
    for (int i = 0; i < 2; i++) begin
      s.s1[i*5 +: 5]  = 5'($urandom_range(0, 7));
      s.s2[i*5 +: 5]  = 5'($urandom_range(0, 7));
      s.d[i*5 +: 5]   = 5'($urandom_range(0, 7));
      s.rob[i*4 +: 4] = 4'($urandom_range(0, 15));
      s.retv[i]       = ($urandom_range(0, 9) < 4);
      r               = $urandom_range(0, 7);
      s.retd[i*5 +: 5] = 5'(r);
      s.retr[i*4 +: 4] = $urandom_range(0, 1) ? m_tbl.id[r] : 4'($urandom_range(0, 15));
    end
    s.creq  = ($urandom_range(0, 2) == 0);
    s.cfree = ($urandom_range(0, 3) == 0);
    if (q_tag.size() > 0 && $urandom_range(0, 9) == 0) begin
      s.rec  = 1'b1;
      s.rtag = 2'(q_tag[$urandom_range(0, q_tag.size() - 1)]);
    end
    s.fl = ($urandom_range(0, 59) == 0);
    return s;
  endfunction

  function automatic void cmp(string nm, logic [7:0] act, logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      n_vec++;
      cmp("src1_valid",    {6'd0, src1_valid},    {6'd0, e.s1v});
      cmp("src1_id",       src1_id & e.s1m,       e.s1id);
      cmp("src2_valid",    {6'd0, src2_valid},    {6'd0, e.s2v});
      cmp("src2_id",       src2_id & e.s2m,       e.s2id);
      cmp("dst_old_valid", {6'd0, dst_old_valid}, {6'd0, e.dv});
      cmp("dst_old_id",    dst_old_id & e.dm,     e.did);
      cmp("ckpt_ready",    {7'd0, ckpt_ready},    {7'd0, e.rdy});
      cmp("ckpt_tag",      {6'd0, ckpt_tag},      {6'd0, e.tag});
    end
  end

  initial begin
    stim_t st;
    reset = 1'b1;
    st    = '0;
    ren_valid = '0; ren_src1 = '0; ren_src2 = '0; ren_dst = '0; ren_rob = '0;
    ret_valid = '0; ret_dst = '0; ret_rob = '0;
    ckpt_req = 1'b0; ckpt_free = 1'b0; recover = 1'b0; recover_tag = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    apply('0);

    // In-group forwarding, then the younger slot's write lands.
    st = '0; st.rv = 2'b11;
    st.d[4:0] = 5; st.rob[3:0] = 3;
    st.s1[9:5] = 5; st.d[9:5] = 5; st.rob[7:4] = 4;
    apply(st);
    st = '0; st.s1[4:0] = 5; apply(st);

    // Retire with mismatching then matching ROB id.
    st = '0; st.rv = 2'b01; st.d[4:0] = 7; st.rob[3:0] = 2; apply(st);
    st = '0; st.retv = 2'b01; st.retd[4:0] = 7; st.retr[3:0] = 1; st.s1[4:0] = 7; apply(st);
    st = '0; st.retv = 2'b01; st.retd[4:0] = 7; st.retr[3:0] = 2;
    st.rv = 2'b01; st.s1[4:0] = 7; apply(st);
    st = '0; st.s1[4:0] = 7; apply(st);

    // Fill all snapshot slots, overflow request, free and wrap.
    for (int k = 0; k < 4; k++) begin
      st = '0; st.rv = 2'b01; st.d[4:0] = 5'(10 + k); st.rob[3:0] = 4'(k); st.creq = 1'b1;
      apply(st);
    end
    st = '0; st.creq = 1'b1; st.rv = 2'b01; st.d[4:0] = 20; st.rob[3:0] = 8; apply(st);
    st = '0; st.cfree = 1'b1; apply(st);
    st = '0; st.s1[4:0] = 20; apply(st);

    // Recover to a snapshot; rename in the recover cycle is dropped.
    st = '0; st.fl = 1'b1; apply(st);
    st = '0; st.rv = 2'b01; st.d[4:0] = 3; st.rob[3:0] = 5; st.creq = 1'b1; apply(st);
    st = '0; st.creq = 1'b1; apply(st);
    st = '0; st.rv = 2'b01; st.d[4:0] = 3; st.rob[3:0] = 9; apply(st);
    st = '0; st.rec = 1'b1; st.rtag = 1; st.rv = 2'b01; st.d[4:0] = 3; st.rob[3:0] = 12;
    st.creq = 1'b1; apply(st);
    st = '0; st.s1[4:0] = 3; st.s2[4:0] = 0; apply(st);

    // A retire clear reaches the snapshot before it is restored.
    st = '0; st.rv = 2'b01; st.d[4:0] = 4; st.rob[3:0] = 6; st.creq = 1'b1; apply(st);
    st = '0; st.retv = 2'b01; st.retd[4:0] = 4; st.retr[3:0] = 6; st.s1[4:0] = 4; apply(st);
    st = '0; st.rec = 1'b1; st.rtag = 2; apply(st);
    st = '0; st.s1[4:0] = 4; apply(st);

    // Flush wins over recover and ckpt_req.
    st = '0; st.fl = 1'b1; st.rec = 1'b1; st.rtag = 0; st.creq = 1'b1;
    st.rv = 2'b01; st.d[4:0] = 5; st.rob[3:0] = 1; apply(st);
    st = '0; st.s1[4:0] = 5; st.s2[4:0] = 4; apply(st);

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        apply('0);
      end
      apply(rand_stim());
    end

    for (int k = 0; k < 5 && q_exp.size() != 0; k++) @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries pending, required 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rat_ckpt.md
Name: rat_ckpt

Overview:
Parametrised register alias table with branch checkpointing. It maps architectural registers to in-flight ROB entries for up to MACHINE_WIDTH instructions per cycle, with in-group forwarding and retire clearing. It adds CKPT_NUM snapshot slots for single-cycle mispredict recovery and a full flush. It sits in the rename stage between decode and dispatch; the ROB drives the retire and recover inputs.

Parameters:
MACHINE_WIDTH, 2, instructions renamed per cycle
RETIRE_PORTS, 2, retire ports per cycle
AREG_NUM, 32, architectural registers; reg 0 is hardwired and never mapped
ROB_W, 4, ROB index width
CKPT_NUM, 4, snapshot slots (power of 2); CKPT_W = clog2(CKPT_NUM)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
ren_valid  in  MACHINE_WIDTH  rename slot valid; slot 0 is oldest
ren_src1 / ren_src2 / ren_dst  in  MACHINE_WIDTH*clog2(AREG_NUM)  architectural indices
ren_rob  in  MACHINE_WIDTH*ROB_W  ROB entry allocated to each slot
src1_valid / src2_valid  out  MACHINE_WIDTH  source is renamed (in flight)
src1_id / src2_id  out  MACHINE_WIDTH*ROB_W  producing ROB entry
dst_old_valid / dst_old_id  out  MACHINE_WIDTH / MACHINE_WIDTH*ROB_W  previous mapping of dst
ret_valid  in  RETIRE_PORTS  retire valid
ret_dst  in  RETIRE_PORTS*clog2(AREG_NUM)  retiring instruction's dst
ret_rob  in  RETIRE_PORTS*ROB_W  retiring instruction's ROB entry
ckpt_req  in  1  take a snapshot after this cycle's rename group
ckpt_ready  out  1  a free slot exists
ckpt_tag  out  CKPT_W  tag the next snapshot receives
ckpt_free  in  1  release the oldest snapshot (branch resolved correct)
recover  in  1  restore the snapshot named by recover_tag
recover_tag  in  CKPT_W  snapshot to restore
flush  in  1  invalidate all mappings and all snapshots

Behaviour:
- State: table[AREG_NUM] of {valid, id}; ckpt[CKPT_NUM] copies of the table; head, tail (CKPT_W, wrapping); count (CKPT_W+1 bits).
- Reset: all table and snapshot entries invalid with id 0; head = tail = count = 0. Outputs at reset: ckpt_ready = 1, ckpt_tag = 0.
- Read path is combinational, with these rules in order:
  - The current table is used, with this cycle's retire clears applied first.
  - For slot i, the youngest valid slot j<i with ren_dst[j] == src and ren_dst[j] != 0 overrides, giving {1, ren_rob[j]}.
  - Any read of reg 0 returns valid = 0, id = 0.
  - dst_old follows the same rule applied to ren_dst.
- Retire: for each valid port p, clear table[ret_dst[p]] only if it is valid and its id == ret_rob[p]. Apply the same compare-and-clear to every live snapshot.
- Rename write: for each valid slot with dst != 0, write table[dst] = {1, rob}. If several slots share a dst, the highest-index slot wins. Rename writes override retire clears on the same entry.
- Checkpoint allocation:
  - Condition: ckpt_req && count < CKPT_NUM && !recover && !flush.
  - Action: ckpt[tail] <= next-state table (after retire and rename); tail++, count++.
  - ckpt_tag = tail; ckpt_ready = (count < CKPT_NUM).
  - ckpt_req when full is ignored; upstream must stall on !ckpt_ready.
- ckpt_free with count > 0: head++, count--. ckpt_free with count == 0 is ignored.
- recover (recover_tag must be live):
  - Table <= ckpt[recover_tag] with this cycle's retire clears applied.
  - The rename write and ckpt_req are suppressed that cycle.
  - tail <= recover_tag + 1; snapshots younger than recover_tag are discarded.
  - count <= (recover_tag − head + 1) mod CKPT_NUM, with a result of 0 treated as CKPT_NUM, minus 1 if ckpt_free is asserted in the same cycle.
- flush: all table and snapshot entries are invalidated; head = tail = count = 0. Priority is flush > recover > rename/ckpt_req. Retire is ignored on a flush cycle.
- Wrap-around: head and tail wrap modulo CKPT_NUM; count disambiguates full from empty.
- Reset asserted mid-operation returns all state to reset values asynchronously.

Test Plan:
1. Reset, then rename slot0 dst=5 rob=3, slot1 src1=5 dst=5 rob=4 → slot1 src1 = {1,3} and dst_old = {1,3}; next cycle table[5] = {1,4}.
2. table[7] = {1,2}; retire dst=7 rob=1 → no change. Retire dst=7 rob=2 while renaming src1=7 → src1 = {0,·}; table[7] is invalid after the edge.
3. Four ckpt_req, each with a rename → tags 0..3 and ckpt_ready = 0. Fifth ckpt_req is ignored. ckpt_free → ckpt_ready = 1, next tag = 0 (wrap).
4. Snapshot tag 1 with table[3] = {1,5}; then rename dst=3 rob=9; recover tag 1 → table[3] = {1,5}, tail = 2, count = 2 (head = 0). A rename presented in the recover cycle is dropped.
5. Snapshot holds table[4] = {1,6}; retire dst=4 rob=6; then recover to that snapshot → table[4] invalid.
6. flush together with recover and ckpt_req → all entries invalid, count = 0, ckpt_tag = 0, ckpt_ready = 1.
